// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
// Holds the frame FSM state enum, prefix bytes and a frame check helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam int PS2_DATA_BITS     = 8;

  // Stop bit must be 1 and data plus parity must hold an odd count of ones.
  function automatic logic frame_ok(
    input logic [7:0] d,
    input logic       p,
    input logic       s
  );
    return s & (^{d, p});
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser plus stability filter for one raw PS/2 line.
// Ports: clock, reset (async low), din (raw), dout (filtered, resets to 1).
module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

  logic       meta_q;
  logic       sync_q;
  logic       filt_q;
  logic       filt_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  // cnt_q counts consecutive samples that disagree with the output;
  // the FILTER_LEN-th such sample flips the output.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: filters lines, deserialises frames.
// Ports: clock, reset (async low), ps2Clk/ps2Data in; scanCode,
// codeValid, frameErr, isBreak, isExtended out. Macro PS2_PREFIX_TRACK_EN.
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] scanCode,
  output logic       codeValid,
  output logic       frameErr,
  output logic       isBreak,
  output logic       isExtended
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0] BIT_LAST = 4'(PS2_DATA_BITS - 1);

  logic clk_f;
  logic dat_f;
  logic clk_prev_q;
  logic fall;

  ps2_state_e    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic [TW-1:0] to_inc;
  logic          to_hit;
  logic [7:0]    scan_q, scan_d;
  logic          cv_q, cv_d;
  logic          fe_q, fe_d;

  ps2_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filt (
    .clock(clock),
    .reset(reset),
    .din  (ps2Clk),
    .dout (clk_f)
  );

  ps2_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_dat_filt (
    .clock(clock),
    .reset(reset),
    .din  (ps2Data),
    .dout (dat_f)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_prev_q <= 1'b1;
    end else begin
      clk_prev_q <= clk_f;
    end
  end

  assign fall = clk_prev_q & ~clk_f;

  // Saturating increment; to_hit fires on the cycle the count reaches
  // the last allowed value with no edge to rescue the frame.
  assign to_inc = (to_q == '1) ? to_q : to_q + 1'b1;
  assign to_hit = !fall && (to_inc == TO_LAST);

`ifdef PS2_PREFIX_TRACK_EN
  logic pend_ext_q, pend_ext_d;
  logic pend_brk_q, pend_brk_d;
  logic ext_q, ext_d;
  logic brk_q, brk_d;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    scan_d    = scan_q;
    cv_d      = 1'b0;
    fe_d      = 1'b0;
    to_d      = (state_q == IDLE || fall) ? '0 : to_inc;
`ifdef PS2_PREFIX_TRACK_EN
    pend_ext_d = pend_ext_q;
    pend_brk_d = pend_brk_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (fall && !dat_f) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {dat_f, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = PARITY;
          end
        end else if (to_hit) begin
          fe_d    = 1'b1;
          state_d = IDLE;
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = dat_f;
          state_d = STOP;
        end else if (to_hit) begin
          fe_d    = 1'b1;
          state_d = IDLE;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (frame_ok(shift_q, par_q, dat_f)) begin
`ifdef PS2_PREFIX_TRACK_EN
            if (shift_q == PS2_EXT) begin
              pend_ext_d = 1'b1;
            end else if (shift_q == PS2_BREAK) begin
              pend_brk_d = 1'b1;
            end else begin
              scan_d     = shift_q;
              cv_d       = 1'b1;
              ext_d      = pend_ext_q;
              brk_d      = pend_brk_q;
              pend_ext_d = 1'b0;
              pend_brk_d = 1'b0;
            end
`else
            scan_d = shift_q;
            cv_d   = 1'b1;
`endif
          end else begin
            fe_d = 1'b1;
          end
        end else if (to_hit) begin
          fe_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef PS2_PREFIX_TRACK_EN
    if (fe_d) begin
      pend_ext_d = 1'b0;
      pend_brk_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_q      <= '0;
      scan_q    <= '0;
      cv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_q      <= to_d;
      scan_q    <= scan_d;
      cv_q      <= cv_d;
      fe_q      <= fe_d;
    end
  end

`ifdef PS2_PREFIX_TRACK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_ext_q <= 1'b0;
      pend_brk_q <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      pend_ext_q <= pend_ext_d;
      pend_brk_q <= pend_brk_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
    end
  end

  assign isExtended = ext_q;
  assign isBreak    = brk_q;
`else
  assign isExtended = 1'b0;
  assign isBreak    = 1'b0;
`endif

  assign scanCode  = scan_q;
  assign codeValid = cv_q;
  assign frameErr  = fe_q;

endmodule
